// File: rtl/match_if.sv
// Game-side and overlay-side signals of the match controller, bundled as one port.
// The master modport is the controller; the slave modport is the game/overlay side.
interface match_if;
    logic       start_btn;
    logic [1:0] finish;
    logic [3:0] p1_health;
    logic [3:0] p2_health;
    logic       game_reset;
    logic [2:0] state;
    logic [1:0] countdown;
    logic [6:0] round_timer;
    logic [2:0] round_num;
    logic [1:0] p1_rounds;
    logic [1:0] p2_rounds;
    logic [1:0] round_winner;
    logic [1:0] match_winner;

    modport master (
        input  start_btn, finish, p1_health, p2_health,
        output game_reset, state, countdown, round_timer, round_num,
               p1_rounds, p2_rounds, round_winner, match_winner
    );

    modport slave (
        output start_btn, finish, p1_health, p2_health,
        input  game_reset, state, countdown, round_timer, round_num,
               p1_rounds, p2_rounds, round_winner, match_winner
    );
endinterface

// File: rtl/match_controller.sv
// Best-of-N match sequencer around the game block; every output is registered and
// reacts one clk after the causing input. There is no backpressure: all inputs are sampled every cycle.
module match_controller #(
    parameter int TICKS_PER_SEC = 100_000_000,
    parameter int COUNTDOWN_SEC = 3,
    parameter int ROUND_SEC     = 60,
    parameter int END_HOLD_SEC  = 2,
    parameter int ROUNDS_TO_WIN = 2
) (
    input  logic    clk,
    input  logic    reset,
    match_if.master bus
);
    localparam int TW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam int HW = $clog2(END_HOLD_SEC + 1);

    localparam logic [TW-1:0] TICK_LAST  = TW'(TICKS_PER_SEC - 1);
    localparam logic [1:0]    CD_LOAD    = 2'(COUNTDOWN_SEC);
    localparam logic [6:0]    RT_LOAD    = 7'(ROUND_SEC);
    localparam logic [HW-1:0] HOLD_LOAD  = HW'(END_HOLD_SEC);
    localparam logic [1:0]    WIN_SCORE  = 2'(ROUNDS_TO_WIN);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        COUNTDOWN = 3'd1,
        FIGHT     = 3'd2,
        ROUND_END = 3'd3,
        MATCH_END = 3'd4
    } state_t;

    state_t        st;
    logic          start_prev;
    logic [TW-1:0] tick_cnt;
    logic [HW-1:0] hold_cnt;
    logic          game_reset_q;
    logic [1:0]    countdown_q;
    logic [6:0]    round_timer_q;
    logic [2:0]    round_num_q;
    logic [1:0]    p1_rounds_q;
    logic [1:0]    p2_rounds_q;
    logic [1:0]    round_winner_q;
    logic [1:0]    match_winner_q;

    logic start_rise;
    logic sec_tick;

    // start_prev resets high so a button held through reset is not seen as a press.
    assign start_rise = bus.start_btn & ~start_prev;
    assign sec_tick   = (tick_cnt == TICK_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st             <= IDLE;
            start_prev     <= 1'b1;
            tick_cnt       <= '0;
            hold_cnt       <= '0;
            game_reset_q   <= 1'b0;
            countdown_q    <= 2'd0;
            round_timer_q  <= 7'd0;
            round_num_q    <= 3'd0;
            p1_rounds_q    <= 2'd0;
            p2_rounds_q    <= 2'd0;
            round_winner_q <= 2'd0;
            match_winner_q <= 2'd0;
        end else begin
            start_prev <= bus.start_btn;
            tick_cnt   <= sec_tick ? '0 : tick_cnt + TW'(1);

            case (st)
                IDLE, MATCH_END: begin
                    if (start_rise) begin
                        st             <= COUNTDOWN;
                        tick_cnt       <= '0;
                        game_reset_q   <= 1'b0;
                        countdown_q    <= CD_LOAD;
                        round_num_q    <= 3'd1;
                        p1_rounds_q    <= 2'd0;
                        p2_rounds_q    <= 2'd0;
                        round_winner_q <= 2'd0;
                        match_winner_q <= 2'd0;
                    end
                end

                COUNTDOWN: begin
                    if (sec_tick) begin
                        if (countdown_q == 2'd1) begin
                            st            <= FIGHT;
                            tick_cnt      <= '0;
                            game_reset_q  <= 1'b1;
                            countdown_q   <= 2'd0;
                            round_timer_q <= RT_LOAD;
                        end else begin
                            countdown_q <= countdown_q - 2'd1;
                        end
                    end
                end

                FIGHT: begin
                    // A KO outranks a timeout landing on the same edge; health is then ignored.
                    if (bus.finish[0]) begin
                        st             <= ROUND_END;
                        tick_cnt       <= '0;
                        hold_cnt       <= HOLD_LOAD;
                        round_winner_q <= bus.finish;
                        if (bus.finish[1]) begin
                            p2_rounds_q <= p2_rounds_q + 2'd1;
                        end else begin
                            p1_rounds_q <= p1_rounds_q + 2'd1;
                        end
                    end else if (sec_tick) begin
                        if (round_timer_q == 7'd1) begin
                            st            <= ROUND_END;
                            tick_cnt      <= '0;
                            hold_cnt      <= HOLD_LOAD;
                            round_timer_q <= 7'd0;
                            if (bus.p1_health > bus.p2_health) begin
                                round_winner_q <= 2'b01;
                                p1_rounds_q    <= p1_rounds_q + 2'd1;
                            end else if (bus.p2_health > bus.p1_health) begin
                                round_winner_q <= 2'b11;
                                p2_rounds_q    <= p2_rounds_q + 2'd1;
                            end else begin
                                round_winner_q <= 2'b00;
                            end
                        end else begin
                            round_timer_q <= round_timer_q - 7'd1;
                        end
                    end
                end

                ROUND_END: begin
                    if (sec_tick) begin
                        if (hold_cnt == HW'(1)) begin
                            tick_cnt <= '0;
                            if (p1_rounds_q == WIN_SCORE) begin
                                st             <= MATCH_END;
                                match_winner_q <= 2'b01;
                            end else if (p2_rounds_q == WIN_SCORE) begin
                                st             <= MATCH_END;
                                match_winner_q <= 2'b11;
                            end else begin
                                st           <= COUNTDOWN;
                                game_reset_q <= 1'b0;
                                countdown_q  <= CD_LOAD;
                                round_num_q  <= (round_num_q == 3'd7) ? 3'd7 : round_num_q + 3'd1;
                            end
                        end else begin
                            hold_cnt <= hold_cnt - HW'(1);
                        end
                    end
                end

                default: begin
                    st           <= IDLE;
                    game_reset_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.state        = st;
    assign bus.game_reset   = game_reset_q;
    assign bus.countdown    = countdown_q;
    assign bus.round_timer  = round_timer_q;
    assign bus.round_num    = round_num_q;
    assign bus.p1_rounds    = p1_rounds_q;
    assign bus.p2_rounds    = p2_rounds_q;
    assign bus.round_winner = round_winner_q;
    assign bus.match_winner = match_winner_q;

endmodule

// File: tb/tb_match_controller.sv
// Directed bench for match_controller with a 4-tick second, 3 s countdown, 5 s rounds, 2 s hold, first to 2.
module tb_match_controller;
    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;

    match_if bus ();

    match_controller #(
        .TICKS_PER_SEC (4),
        .COUNTDOWN_SEC (3),
        .ROUND_SEC     (5),
        .END_HOLD_SEC  (2),
        .ROUNDS_TO_WIN (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press_start();
        bus.start_btn = 1'b0;
        step(1);
        bus.start_btn = 1'b1;
        step(1);
    endtask

    initial begin
        logic [12:0] snap;
        logic [12:0] snap_exp;

        n_cmp = 0;
        n_err = 0;
        reset = 1'b0;
        bus.start_btn = 1'b1;
        bus.finish    = 2'b00;
        bus.p1_health = 4'd0;
        bus.p2_health = 4'd0;

        step(3);
        chk("rst_state",        bus.state,        0);
        chk("rst_game_reset",   bus.game_reset,   0);
        chk("rst_countdown",    bus.countdown,    0);
        chk("rst_round_timer",  bus.round_timer,  0);
        chk("rst_round_num",    bus.round_num,    0);
        chk("rst_p1_rounds",    bus.p1_rounds,    0);
        chk("rst_p2_rounds",    bus.p2_rounds,    0);
        chk("rst_round_winner", bus.round_winner, 0);
        chk("rst_match_winner", bus.match_winner, 0);

        // Button held through reset release must not start a match.
        reset = 1'b1;
        step(3);
        chk("held_no_start", bus.state, 0);
        bus.start_btn = 1'b0;
        step(2);
        chk("released_idle", bus.state, 0);
        bus.start_btn = 1'b1;
        step(1);
        chk("start_state",      bus.state,      1);
        chk("start_game_reset", bus.game_reset, 0);
        chk("start_round_num",  bus.round_num,  1);

        for (int k = 0; k < 12; k++) begin
            chk("cd_value", bus.countdown, 3 - k / 4);
            chk("cd_state", bus.state, 1);
            step(1);
        end
        chk("fight_state",      bus.state,       2);
        chk("fight_game_reset", bus.game_reset,  1);
        chk("fight_timer",      bus.round_timer, 5);
        chk("fight_countdown",  bus.countdown,   0);

        // Round 1: P1 KO.
        bus.finish = 2'b01;
        step(1);
        bus.finish = 2'b00;
        chk("ko_state",   bus.state,        3);
        chk("ko_p1",      bus.p1_rounds,    1);
        chk("ko_winner",  bus.round_winner, 1);
        chk("ko_timer",   bus.round_timer,  5);
        step(7);
        chk("hold_last_cycle", bus.state, 3);
        step(1);
        chk("r2_state",      bus.state,      1);
        chk("r2_round_num",  bus.round_num,  2);
        chk("r2_game_reset", bus.game_reset, 0);
        chk("r2_countdown",  bus.countdown,  3);

        // Round 2: timeout, P2 healthier.
        step(12);
        chk("r2_fight", bus.state, 2);
        bus.p1_health = 4'd7;
        bus.p2_health = 4'd9;
        step(19);
        chk("to_pre_state", bus.state,       2);
        chk("to_pre_timer", bus.round_timer, 1);
        step(1);
        chk("to_state",  bus.state,        3);
        chk("to_timer",  bus.round_timer,  0);
        chk("to_p2",     bus.p2_rounds,    1);
        chk("to_p1",     bus.p1_rounds,    1);
        chk("to_winner", bus.round_winner, 3);
        step(8);
        chk("r3_round_num", bus.round_num, 3);

        // Round 3: timeout with equal health is a draw.
        step(12);
        bus.p1_health = 4'd5;
        bus.p2_health = 4'd5;
        step(20);
        chk("draw_state",  bus.state,        3);
        chk("draw_winner", bus.round_winner, 0);
        chk("draw_p1",     bus.p1_rounds,    1);
        chk("draw_p2",     bus.p2_rounds,    1);
        step(8);
        chk("r4_state",     bus.state,     1);
        chk("r4_round_num", bus.round_num, 4);

        // Round 4: P2 KO on the timeout edge while P1 has more health.
        step(12);
        bus.p1_health = 4'd9;
        bus.p2_health = 4'd3;
        step(19);
        chk("sim_pre_timer", bus.round_timer, 1);
        bus.finish = 2'b11;
        step(1);
        bus.finish = 2'b00;
        chk("sim_state",  bus.state,        3);
        chk("sim_winner", bus.round_winner, 3);
        chk("sim_p2",     bus.p2_rounds,    2);
        chk("sim_p1",     bus.p1_rounds,    1);
        step(8);
        chk("m1_state",      bus.state,        4);
        chk("m1_winner",     bus.match_winner, 3);
        chk("m1_game_reset", bus.game_reset,   1);

        // Second match: P1 takes two KO rounds.
        press_start();
        chk("m2_state",   bus.state,        1);
        chk("m2_p1",      bus.p1_rounds,    0);
        chk("m2_p2",      bus.p2_rounds,    0);
        chk("m2_rnum",    bus.round_num,    1);
        chk("m2_mwin",    bus.match_winner, 0);
        chk("m2_rwin",    bus.round_winner, 0);
        step(12);
        bus.finish = 2'b01;
        step(1);
        bus.finish = 2'b00;
        step(8);
        step(12);
        chk("m2r2_fight", bus.state, 2);
        bus.finish = 2'b01;
        step(1);
        bus.finish = 2'b00;
        chk("m2r2_p1", bus.p1_rounds, 2);
        step(8);
        chk("m2_end_state", bus.state,        4);
        chk("m2_end_mwin",  bus.match_winner, 1);

        snap_exp = {3'd4, 2'b01, 2'd2, 2'd0, 2'b01, 1'b1, 1'b0};
        for (int k = 0; k < 100; k++) begin
            step(1);
            snap = {bus.state, bus.match_winner, bus.p1_rounds, bus.p2_rounds,
                    bus.round_winner, bus.game_reset, 1'b0};
            chk("m2_end_stable", int'(snap), int'(snap_exp));
        end

        press_start();
        chk("m3_state", bus.state,        1);
        chk("m3_p1",    bus.p1_rounds,    0);
        chk("m3_rnum",  bus.round_num,    1);
        chk("m3_mwin",  bus.match_winner, 0);

        // Async reset between edges, mid-fight.
        step(14);
        chk("m3_fight", bus.state, 2);
        #2;
        reset = 1'b0;
        #1;
        chk("async_state",      bus.state,       0);
        chk("async_game_reset", bus.game_reset,  0);
        chk("async_countdown",  bus.countdown,   0);
        chk("async_timer",      bus.round_timer, 0);
        chk("async_round_num",  bus.round_num,   0);
        chk("async_p1",         bus.p1_rounds,   0);
        chk("async_p2",         bus.p2_rounds,   0);
        reset = 1'b1;
        step(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/match_controller.md
# match_controller

Sequences a best-of-N match around the core game block: holds the game in reset during idle and pre-round countdown, releases it for the fight, watches its `finish` flags and health outputs to award rounds (KO or timeout), and declares a match winner. Sits between the debounced start input and the game block. It drives the game's active-low `reset` and supplies countdown, timer and score values to the VGA overlay.

## Interface
- `TICKS_PER_SEC`, 100_000_000: clk cycles per game second.
- `COUNTDOWN_SEC`, 3: pre-round countdown length in seconds (1..3).
- `ROUND_SEC`, 60: round time limit in seconds (1..127).
- `END_HOLD_SEC`, 2: round-end display hold in seconds (≥1).
- `ROUNDS_TO_WIN`, 2: round wins needed to take the match (1..3).

- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-low reset.
- `start_btn`  in  1  debounced start level; acted on at its rising edge only.
- `finish`  in  2  from game: 00 playing, 01 P1 KO win, 11 P2 KO win.
- `p1_health`, `p2_health`  in  4  each, from game.
- `game_reset`  out  1  active-low reset to game block.
- `state`  out  3  0 IDLE, 1 COUNTDOWN, 2 FIGHT, 3 ROUND_END, 4 MATCH_END.
- `countdown`  out  2  seconds remaining in COUNTDOWN, else 0.
- `round_timer`  out  7  seconds remaining in FIGHT; holds value in ROUND_END/MATCH_END; 0 in IDLE.
- `round_num`  out  3  current round, 1-based, saturates at 7; 0 in IDLE.
- `p1_rounds`, `p2_rounds`  out  2  rounds won this match.
- `round_winner`  out  2  00 none/draw, 01 P1, 11 P2; last completed round.
- `match_winner`  out  2  00 none, 01 P1, 11 P2.

## Operation
- All outputs are registered. Reset values: state IDLE, `game_reset` 0, all counts/scores/winners 0.
- Start edge: `start_rise = start_btn & ~start_prev`. `start_prev` resets to 1, so a button held through reset does not start a match.
- Second tick: `tick_cnt` counts 0..TICKS_PER_SEC-1. `sec_tick` is asserted on the terminal count. `tick_cnt` clears on every state entry, so the first second after entry is full length.
- `game_reset` is 0 in IDLE and COUNTDOWN, and 1 in FIGHT, ROUND_END and MATCH_END. The game is frozen and repositioned during countdown.

State behaviour:
- IDLE: on `start_rise` → COUNTDOWN. Entry actions: scores and winners cleared, `round_num` = 1, `countdown` = COUNTDOWN_SEC.
- COUNTDOWN: each `sec_tick` decrements `countdown`. On `sec_tick` with `countdown` = 1 → FIGHT, with `countdown` = 0 and `round_timer` = ROUND_SEC.
- FIGHT, KO: `finish[0]` = 1 → ROUND_END. `round_winner` = `finish` (01 or 11). The matching score increments.
- FIGHT, timeout: otherwise, each `sec_tick` decrements `round_timer`. On `sec_tick` with `round_timer` = 1 → ROUND_END with `round_timer` = 0.
  - Higher health wins the round and its score increments.
  - Equal health: `round_winner` = 00, no score change.
- FIGHT, simultaneous KO and timeout in the same cycle: KO has priority and health is not compared.
- ROUND_END: held END_HOLD_SEC seconds. On the final `sec_tick`:
  - If either score = ROUNDS_TO_WIN → MATCH_END, with `match_winner` = 01 or 11.
  - Otherwise → COUNTDOWN, with `round_num` + 1 (saturating) and `countdown` reloaded.
- MATCH_END: outputs hold. On `start_rise` → COUNTDOWN with the same entry actions as leaving IDLE (new match).
- `start_rise` is ignored in COUNTDOWN, FIGHT and ROUND_END.
- Scores never exceed ROUNDS_TO_WIN. The match ends on the round that reaches it, and draws do not count.
- Async reset mid-match returns to IDLE immediately and asserts `game_reset` low in the same instant.

## Timing
- `start_rise` at cycle N: `state` = COUNTDOWN and `game_reset` = 0 visible at N+1.
- COUNTDOWN lasts exactly COUNTDOWN_SEC·TICKS_PER_SEC cycles. `game_reset` rises together with `state` = FIGHT.
- KO detect latency: `finish[0]` sampled at edge N gives `state` = ROUND_END and updated score at N+1.
- Timeout: FIGHT lasts exactly ROUND_SEC·TICKS_PER_SEC cycles when no KO occurs.
- ROUND_END lasts exactly END_HOLD_SEC·TICKS_PER_SEC cycles.
- In the first COUNTDOWN cycle the game is held in reset, so `finish` returns to 00 before the next FIGHT.

## Test plan
All scenarios use TICKS_PER_SEC=4, COUNTDOWN_SEC=3, ROUND_SEC=5, END_HOLD_SEC=2, ROUNDS_TO_WIN=2.
- Reset with `start_btn` held high, then release, then press: no start while held → COUNTDOWN one cycle after the new rising edge. `countdown` reads 3,2,1 for 4 cycles each, then FIGHT with `game_reset` = 1 and `round_timer` = 5.
- KO path: in FIGHT drive `finish` = 01 → next cycle ROUND_END, `p1_rounds` = 1, `round_winner` = 01. After 8 cycles → COUNTDOWN, `round_num` = 2, `game_reset` = 0.
- Timeout path: no KO, health P1=7 / P2=9 → after 20 FIGHT cycles `round_timer` = 0, `p2_rounds` +1. With equal health 5/5 → `round_winner` = 00 and scores unchanged.
- Simultaneous: `finish` = 11 asserted on the cycle `round_timer` 1→0 with P1 health higher → P2 is awarded the round.
- Match completion: P1 wins two rounds → MATCH_END, `match_winner` = 01, outputs stable for 100 cycles. A start edge then → COUNTDOWN with scores 0, `round_num` = 1, `match_winner` = 00.
- Async reset asserted mid-FIGHT (between clock edges) → `state` = IDLE and `game_reset` = 0 immediately, with all counters at 0.
